// File: rtl/fetch_stage.sv
// Fetch front end: owns the fetch PC, issues in-order word requests to instruction
// memory, queues returned words under a credit cap and hands them to decode.
module fetch_stage #(
   parameter logic [29:0] RESET_PC = 30'h0,
   parameter int          QDEPTH   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_redirect_valid,
   input  logic [29:0] i_redirect_pc,
   output logic        o_imem_req_valid,
   output logic [29:0] o_imem_req_addr,
   input  logic        i_imem_req_ready,
   input  logic        i_imem_resp_valid,
   input  logic [31:0] i_imem_resp_data,
   output logic        o_d_valid,
   input  logic        i_d_stall,
   output logic [31:0] o_instr_out,
   output logic [29:0] o_pc_out
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0] LP_DEPTH = (CW + 1)'(QDEPTH);

   logic [29:0]   r_fetch_pc;
   logic [31:0]   r_q_instr [QDEPTH];
   logic [29:0]   r_q_pc    [QDEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [29:0]   r_req_pc  [QDEPTH];
   logic [PW-1:0] r_req_head;
   logic [PW-1:0] r_req_tail;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop_count;

   logic [CW:0]   w_credit_sum;
   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_enq;
   logic          w_pop;
   logic [29:0]   w_resp_pc;

   // Queued entries plus in-flight requests never exceed QDEPTH, so every
   // response that is kept always finds a free queue slot.
   assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_req_valid  = i_rst && !i_redirect_valid && (w_credit_sum < LP_DEPTH);
   assign w_req_fire   = w_req_valid && i_imem_req_ready;
   assign w_resp_pc    = r_req_pc[r_req_head];
   assign w_enq        = i_imem_resp_valid && (r_drop_count == '0) && !i_redirect_valid;
   assign w_pop        = (r_count != '0) && !i_d_stall && !i_redirect_valid;

   assign o_imem_req_valid = w_req_valid;
   assign o_imem_req_addr  = r_fetch_pc;
   assign o_d_valid        = (r_count != '0);
   assign o_instr_out      = r_q_instr[r_head];
   assign o_pc_out         = r_q_pc[r_head];

   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_q_instr[r_tail] <= i_imem_resp_data;
         r_q_pc[r_tail]    <= w_resp_pc;
      end
      if (w_req_fire) begin
         r_req_pc[r_req_tail] <= r_fetch_pc;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_fetch_pc    <= RESET_PC;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_req_head    <= '0;
         r_req_tail    <= '0;
         r_outstanding <= '0;
         r_drop_count  <= '0;
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + 30'd1;
            r_req_tail <= r_req_tail + PW'(1);
         end
         if (i_imem_resp_valid) begin
            r_req_head <= r_req_head + PW'(1);
         end
         r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(i_imem_resp_valid);

         // Redirect: every request still in flight after this edge is wrong-path.
         if (i_redirect_valid) begin
            r_fetch_pc   <= i_redirect_pc;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_drop_count <= r_outstanding - CW'(i_imem_resp_valid);
         end else begin
            if (w_enq) begin
               r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
               r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_pop);
            if (i_imem_resp_valid && (r_drop_count != '0)) begin
               r_drop_count <= r_drop_count - CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst && w_enq) begin
         assert (r_count < CW'(QDEPTH));
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model, queue-level reference model of the
// delivered instruction stream, directed scenarios followed by randomized traffic.
module tb_fetch_stage;

   localparam logic [29:0] RST_PC = 30'h100;
   localparam int          QD     = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redir_v = 1'b0;
   logic [29:0] redir_pc = '0;
   logic        req_v;
   logic [29:0] req_addr;
   logic        req_rdy = 1'b1;
   logic        resp_v = 1'b0;
   logic [31:0] resp_data = '0;
   logic        d_valid;
   logic        d_stall = 1'b0;
   logic [31:0] instr;
   logic [29:0] pc;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
      .i_clk            (clk),
      .i_rst            (rst_n),
      .i_redirect_valid (redir_v),
      .i_redirect_pc    (redir_pc),
      .o_imem_req_valid (req_v),
      .o_imem_req_addr  (req_addr),
      .i_imem_req_ready (req_rdy),
      .i_imem_resp_valid(resp_v),
      .i_imem_resp_data (resp_data),
      .o_d_valid        (d_valid),
      .i_d_stall        (d_stall),
      .o_instr_out      (instr),
      .o_pc_out         (pc)
   );

   function automatic logic [31:0] memf(input logic [29:0] a);
      return {a[13:0], a[29:12]} ^ 32'hC0DE_5A17;
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      $display("FAIL %s at t=%0t", name, $time);
   endtask

   // ---------------- reference model state ----------------
   logic [29:0] m_pc = RST_PC;
   logic [29:0] exp_q[$];      // pcs visible to decode, head first
   logic [29:0] fl_pc[$];      // requests in flight, oldest first
   bit          fl_drop[$];    // in-flight request belongs to a squashed path

   // ---------------- memory model ----------------
   int          pend_due[$];
   logic [29:0] pend_addr[$];
   int          last_due = 0;
   int          cyc = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          seen_300 = 1'b0;

   // values seen by the DUT during the cycle that ends at the next posedge
   bit          s_ok = 1'b0;
   bit          s_redir, s_rdy, s_stall, s_resp, s_dut_req;
   logic [29:0] s_rpc, s_dut_addr;

   // ---------------- compare process ----------------
   always @(negedge clk) begin : cmp
      bit exp_rv;
      s_ok       = rst_n;
      s_redir    = redir_v;
      s_rpc      = redir_pc;
      s_rdy      = req_rdy;
      s_stall    = d_stall;
      s_resp     = resp_v;
      s_dut_req  = req_v;
      s_dut_addr = req_addr;
      if (rst_n) begin
         exp_rv = !redir_v && ((exp_q.size() + fl_pc.size()) < QD);
         check("req_valid", 32'(req_v), 32'(exp_rv));
         if (exp_rv) check("req_addr", 32'(req_addr), 32'(m_pc));
         check("d_valid", 32'(d_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("pc_out", 32'(pc), 32'(exp_q[0]));
            check("instr_out", instr, memf(exp_q[0]));
         end
      end
   end

   // ---------------- model + memory step ----------------
   always @(posedge clk) begin : env
      bit          rv, deliver, drop;
      logic [29:0] rpc;
      int          due;
      cyc++;
      if (!rst_n) begin
         m_pc = RST_PC;
         exp_q.delete(); fl_pc.delete(); fl_drop.delete();
         pend_due.delete(); pend_addr.delete();
         last_due = 0;
      end else if (s_ok) begin
         rv      = !s_redir && ((exp_q.size() + fl_pc.size()) < QD);
         deliver = 1'b0;
         rpc     = '0;
         if (s_resp) begin
            if (fl_pc.size() == 0) note_fail("resp_without_request");
            else begin
               rpc  = fl_pc.pop_front();
               drop = fl_drop.pop_front();
               deliver = !drop && !s_redir;
            end
         end
         if (!s_redir && (exp_q.size() != 0) && !s_stall) void'(exp_q.pop_front());
         if (deliver) exp_q.push_back(rpc);
         if (rv && s_rdy) begin
            fl_pc.push_back(m_pc);
            fl_drop.push_back(1'b0);
            m_pc = m_pc + 30'd1;
         end
         if (s_redir) begin
            exp_q.delete();
            foreach (fl_drop[i]) fl_drop[i] = 1'b1;
            m_pc = s_rpc;
         end
         // memory follows what the DUT actually requested
         if (s_dut_req && s_rdy) begin
            due = (cyc - 1) + int'($urandom_range(lat_lo, lat_hi));
            if (due <= last_due) due = last_due + 1;
            pend_due.push_back(due);
            pend_addr.push_back(s_dut_addr);
            last_due = due;
            if (s_dut_addr >= 30'h300 && s_dut_addr < 30'h310) seen_300 = 1'b1;
         end
      end
      #1;
      if (rst_n && (pend_due.size() != 0) && (pend_due[0] <= cyc)) begin
         resp_v    = 1'b1;
         resp_data = memf(pend_addr[0]);
         void'(pend_due.pop_front());
         void'(pend_addr.pop_front());
      end else begin
         resp_v    = 1'b0;
         resp_data = $urandom;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; reset goes low mid-cycle and is released two edges later,
   // returning at posedge+1 of cycle 0 of the new run.
   task automatic async_reset();
      #1;
      rst_n  = 1'b0;
      resp_v = 1'b0;
      #1;
      check("rst_d_valid", 32'(d_valid), 32'd0);
      check("rst_req_valid", 32'(req_v), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge where d_valid is first seen.
   task automatic wait_first_dvalid(input int limit, output int ncyc, output bit found);
      found = 1'b0;
      ncyc  = 0;
      for (int i = 0; i <= limit; i++) begin
         if (d_valid === 1'b1) begin
            found = 1'b1;
            ncyc  = i;
            break;
         end
         step();
         @(negedge clk);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int          acc, n, stall_pct;
      bit          stable, found;
      logic [29:0] a;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_d_valid", 32'(d_valid), 32'd0);
      check("reset_req_valid", 32'(req_v), 32'd0);
      step();
      rst_n = 1'b1;

      // streaming from RESET_PC with a 1-cycle memory
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k <= 2) begin
            check("t1_req_valid", 32'(req_v), 32'd1);
            check("t1_req_addr", 32'(req_addr), 32'(RST_PC) + 32'(k));
         end
         check("t1_d_valid", 32'(d_valid), 32'(k >= 2));
         if (k >= 2) check("t1_pc_out", 32'(pc), 32'(RST_PC) + 32'(k - 2));
         step();
      end

      // reset mid-burst, then decode stalled from the first cycle
      d_stall = 1'b1;
      async_reset();
      acc = 0;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req_v === 1'b1 && req_rdy) acc++;
         if (k == 0) check("t2_first_addr", 32'(req_addr), 32'(RST_PC));
         if (k >= 2 && (d_valid !== 1'b1 || pc !== RST_PC || instr !== memf(RST_PC))) stable = 1'b0;
         if (k < 9) step();
      end
      check("t2_accepted", 32'(acc), 32'd4);
      check("t2_req_blocked", 32'(req_v), 32'd0);
      check("t2_held_stable", 32'(stable), 32'd1);
      step();
      d_stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t2_drain_valid", 32'(d_valid), 32'd1);
         check("t2_drain_pc", 32'(pc), 32'(RST_PC) + 32'(k));
         if (k == 1) begin
            check("t2_resume_valid", 32'(req_v), 32'd1);
            check("t2_resume_addr", 32'(req_addr), 32'(RST_PC) + 32'd4);
         end
         step();
      end

      // 3-cycle memory, redirect with three requests in flight
      lat_lo = 3;
      lat_hi = 3;
      async_reset();
      repeat (3) step();
      redir_v  = 1'b1;
      redir_pc = 30'h200;
      @(negedge clk);
      check("t3_req_blocked", 32'(req_v), 32'd0);
      step();
      redir_v = 1'b0;
      @(negedge clk);
      check("t3_new_req_valid", 32'(req_v), 32'd1);
      check("t3_new_req_addr", 32'(req_addr), 32'h200);
      wait_first_dvalid(16, n, found);
      check("t3_found", 32'(found), 32'd1);
      check("t3_latency", 32'(n), 32'd4);
      check("t3_pc", 32'(pc), 32'h200);
      check("t3_instr", instr, memf(30'h200));
      step();

      // redirect coinciding with a response and a pop, target near the wrap point
      lat_lo = 1;
      lat_hi = 1;
      async_reset();
      repeat (5) step();
      redir_v  = 1'b1;
      redir_pc = 30'h3FFF_FFFE;
      @(negedge clk);
      check("t4_pop_cycle_dvalid", 32'(d_valid), 32'd1);
      check("t4_req_blocked", 32'(req_v), 32'd0);
      step();
      redir_v = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("t4_d_valid", 32'(d_valid), 32'(k >= 3));
         if (k <= 3) begin
            a = 30'h3FFF_FFFE + 30'(k - 1);
            check("t4_req_valid", 32'(req_v), 32'd1);
            check("t4_req_addr", 32'(req_addr), 32'(a));
         end
         if (k >= 3) begin
            a = 30'h3FFF_FFFE + 30'(k - 3);
            check("t4_pc_out", 32'(pc), 32'(a));
         end
         step();
      end

      // back-to-back redirects: the second wins
      seen_300 = 1'b0;
      redir_v  = 1'b1;
      redir_pc = 30'h300;
      @(negedge clk);
      check("t5_req_blocked_a", 32'(req_v), 32'd0);
      step();
      redir_pc = 30'h400;
      @(negedge clk);
      check("t5_req_blocked_b", 32'(req_v), 32'd0);
      step();
      redir_v = 1'b0;
      @(negedge clk);
      check("t5_req_addr", 32'(req_addr), 32'h400);
      wait_first_dvalid(16, n, found);
      check("t5_found", 32'(found), 32'd1);
      check("t5_latency", 32'(n), 32'd2);
      check("t5_pc", 32'(pc), 32'h400);
      check("t5_instr", instr, memf(30'h400));
      repeat (8) step();
      check("t5_no_0x300_request", 32'(seen_300), 32'd0);

      // randomized traffic
      stall_pct = 20;
      for (int i = 0; i < 2500; i++) begin
         step();
         if (i % 250 == 0) begin
            lat_hi = int'($urandom_range(1, 4));
            case ($urandom_range(0, 2))
               0: stall_pct = 10;
               1: stall_pct = 50;
               default: stall_pct = 90;
            endcase
         end
         if (i == 1300) begin
            redir_v = 1'b0;
            async_reset();
         end else begin
            req_rdy = ($urandom_range(0, 3) != 0);
            d_stall = ($urandom_range(0, 99) < stall_pct);
            redir_v = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) redir_pc = 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
            else redir_pc = 30'($urandom);
         end
      end
      redir_v = 1'b0;
      d_stall = 1'b0;
      req_rdy = 1'b1;
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
